// File: rtl/mem_arbiter_if.sv
// Requester (IF, MEM) and byte-wide RAM signals of mem_arbiter.
// master = arbiter side, slave = requesters plus RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF/MEM onto one byte-wide RAM port, serialising 1/2/4-byte little-endian accesses.
// Latency: read n bytes -> done in cycle n+2, write n bytes -> done in cycle n+1, one IDLE cycle between.
// Backpressure: requesters hold req until their done pulse; MEMCTRL_ROUND_ROBIN_EN selects round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [2:0]        c;
  logic [2:0]        n;
  logic [ADDR_W-1:0] base;
  logic              we;
  logic              owner;   // 1 = MEM, 0 = IF
  logic [31:0]       wdata;
  logic [31:0]       dbuf;

  logic              grant_mem;
  logic [2:0]        len_n;
  logic [2:0]        c_nx;
  logic [2:0]        n_m1;
  logic [2:0]        c_m1;
  logic [2:0]        rd_idx;
  logic [7:0]        wr_byte;
  logic [31:0]       rd_word;

`ifdef MEMCTRL_ROUND_ROBIN_EN
  logic last_owner;

  always_comb begin
    grant_mem = bus.mem_req && (!bus.if_req || !last_owner);
  end
`else
  always_comb begin
    grant_mem = bus.mem_req;
  end
`endif

  always_comb begin
    case (bus.mem_len)
      2'b00:   len_n = 3'd1;
      2'b01:   len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  assign c_nx    = c + 3'd1;
  assign n_m1    = n - 3'd1;
  assign c_m1    = c - 3'd1;
  // The read address stops at the last byte while the final byte is still in flight.
  assign rd_idx  = (c_nx > n_m1) ? n_m1 : c_nx;
  assign wr_byte = wdata[8*c_nx[1:0] +: 8];

  always_comb begin
    rd_word = dbuf;
    rd_word[8*c_m1[1:0] +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      c             <= 3'd0;
      n             <= 3'd4;
      base          <= '0;
      we            <= 1'b0;
      owner         <= 1'b0;
      wdata         <= 32'h0;
      dbuf          <= 32'h0;
      bus.ram_a     <= '0;
      bus.ram_wr    <= 1'b0;
      bus.ram_dout  <= 8'h00;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.if_inst   <= 32'h0;
      bus.mem_rdata <= 32'h0;
      bus.busy      <= 1'b0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      last_owner    <= 1'b0;
`endif
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            state    <= BUSY;
            c        <= 3'd0;
            dbuf     <= 32'h0;
            bus.busy <= 1'b1;
`ifdef MEMCTRL_ROUND_ROBIN_EN
            last_owner <= grant_mem;
`endif
            if (grant_mem) begin
              owner        <= 1'b1;
              base         <= bus.mem_addr;
              n            <= len_n;
              we           <= bus.mem_we;
              wdata        <= bus.mem_wdata;
              bus.ram_a    <= bus.mem_addr;
              bus.ram_wr   <= bus.mem_we;
              bus.ram_dout <= bus.mem_we ? bus.mem_wdata[7:0] : 8'h00;
            end else begin
              owner        <= 1'b0;
              base         <= bus.if_addr;
              n            <= 3'd4;
              we           <= 1'b0;
              wdata        <= 32'h0;
              bus.ram_a    <= bus.if_addr;
              bus.ram_wr   <= 1'b0;
              bus.ram_dout <= 8'h00;
            end
          end
        end
        BUSY: begin
          if (we) begin
            if (c == n_m1) begin
              state        <= DONE;
              bus.ram_a    <= '0;
              bus.ram_wr   <= 1'b0;
              bus.ram_dout <= 8'h00;
              if (owner) bus.mem_done <= 1'b1;
              else       bus.if_done  <= 1'b1;
            end else begin
              c            <= c_nx;
              bus.ram_a    <= base + ADDR_W'(c_nx);
              bus.ram_dout <= wr_byte;
            end
          end else begin
            if (c != 3'd0) dbuf <= rd_word;
            if (c == n) begin
              state     <= DONE;
              bus.ram_a <= '0;
              if (owner) begin
                bus.mem_rdata <= rd_word;
                bus.mem_done  <= 1'b1;
              end else begin
                bus.if_inst <= rd_word;
                bus.if_done <= 1'b1;
              end
            end else begin
              c         <= c_nx;
              bus.ram_a <= base + ADDR_W'(rd_idx);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          c        <= 3'd0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a registered byte-RAM model and absolute cycle stamps.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  logic        pre_we;
  logic [31:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  ram_mem [logic [31:0]];

  logic [31:0] chain_addr;
  int          chain_cnt;

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  // RAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.ram_din <= ram_rd(bus.ram_a);
    if (pre_we) ram_mem[pre_a] = pre_d;
    else if (bus.ram_wr) ram_mem[bus.ram_a] = bus.ram_dout;
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] bytes, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = a + 32'(i);
      pre_d  = bytes[8*i +: 8];
      @(negedge clk);
      pre_we = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((bus.busy || bus.if_done || bus.mem_done) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: busy=%0b still high after %0d cycles, required 0", bus.busy, k);
    end
  endtask

  task automatic push_exp(input bit is_mem, input bit chk, input logic [31:0] d, input int at);
    exp_t e;
    e.is_mem = is_mem; e.chk_data = chk; e.data = d; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic run_sb(input string name, input int budget);
    exp_t        e;
    logic [31:0] got;
    int          k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.if_done || bus.mem_done) begin
        e = sb.pop_front();
        n_chk++;
        if (bus.if_done && bus.mem_done || bus.mem_done !== e.is_mem) begin
          n_fail++;
          $display("FAIL %s owner: if_done=%0b mem_done=%0b, required mem_done=%0b only", name,
                   bus.if_done, bus.mem_done, e.is_mem);
        end
        n_chk++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, e.cyc);
        end
        if (e.chk_data) begin
          got = e.is_mem ? bus.mem_rdata : bus.if_inst;
          n_chk++;
          if (got !== e.data) begin
            n_fail++;
            $display("FAIL %s data: got %h, required %h", name, got, e.data);
          end
        end
        if (bus.if_done) begin
          if (chain_cnt > 0) begin
            bus.if_addr = chain_addr;
            chain_cnt--;
          end else begin
            bus.if_req = 1'b0;
          end
        end
        if (bus.mem_done) bus.mem_req = 1'b0;
      end
    end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: %0d transactions outstanding after %0d cycles, required 0", name, sb.size(), k);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus.ram_a !== 32'h0)     begin n_fail++; $display("FAIL reset ram_a: got %h, required 0", bus.ram_a); end
    n_chk++; if (bus.ram_wr !== 1'b0)     begin n_fail++; $display("FAIL reset ram_wr: got %b, required 0", bus.ram_wr); end
    n_chk++; if (bus.ram_dout !== 8'h0)   begin n_fail++; $display("FAIL reset ram_dout: got %h, required 0", bus.ram_dout); end
    n_chk++; if (bus.if_done !== 1'b0)    begin n_fail++; $display("FAIL reset if_done: got %b, required 0", bus.if_done); end
    n_chk++; if (bus.mem_done !== 1'b0)   begin n_fail++; $display("FAIL reset mem_done: got %b, required 0", bus.mem_done); end
    n_chk++; if (bus.if_inst !== 32'h0)   begin n_fail++; $display("FAIL reset if_inst: got %h, required 0", bus.if_inst); end
    n_chk++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset mem_rdata: got %h, required 0", bus.mem_rdata); end
    n_chk++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset busy: got %b, required 0", bus.busy); end
    rst = 1'b1;
  endtask

  task automatic test_word_fetch();
    logic [31:0] a_exp;
    int s;
    preload(32'h100, 32'h00100513, 4);
    wait_idle();
    s = cyc;
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    push_exp(1'b0, 1'b1, 32'h00100513, s + 6);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.if_addr = 32'hDEAD0000;
      a_exp = 32'h100 + 32'((i > 4) ? 3 : i - 1);
      n_chk++;
      if (bus.ram_a !== a_exp || bus.ram_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch addr c%0d: ram_a=%h ram_wr=%b, required %h/0", i, bus.ram_a, bus.ram_wr, a_exp);
      end
    end
    run_sb("word_fetch", 20);
  endtask

  task automatic test_wrap();
    logic [31:0] a_exp;
    int s;
    preload(32'hFFFFFFFF, 32'h00000011, 1);
    preload(32'h0, 32'h00443322, 3);
    wait_idle();
    s = cyc;
    bus.mem_we = 1'b0; bus.mem_len = 2'b11; bus.mem_addr = 32'hFFFFFFFF;
    bus.mem_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'h44332211, s + 6);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      a_exp = 32'hFFFFFFFF + 32'(i - 1);
      n_chk++;
      if (bus.ram_a !== a_exp) begin
        n_fail++;
        $display("FAIL wrap addr c%0d: ram_a=%h, required %h", i, bus.ram_a, a_exp);
      end
    end
    run_sb("wrap", 20);
  endtask

  task automatic test_half_load();
    int s;
    preload(32'h201, 32'h0000CDAB, 2);
    wait_idle();
    s = cyc;
    bus.mem_we = 1'b0; bus.mem_len = 2'b01; bus.mem_addr = 32'h201;
    bus.mem_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0000CDAB, s + 4);
    run_sb("half_load", 20);
  endtask

  task automatic test_byte_store();
    int s;
    wait_idle();
    s = cyc;
    bus.mem_we = 1'b1; bus.mem_len = 2'b00; bus.mem_addr = 32'h30; bus.mem_wdata = 32'h11223344;
    bus.mem_req = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0, s + 2);
    @(negedge clk);
    n_chk++;
    if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h30 || bus.ram_dout !== 8'h44) begin
      n_fail++;
      $display("FAIL byte_store bus: wr=%b a=%h d=%h, required 1/00000030/44", bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    run_sb("byte_store", 20);
    bus.mem_we = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.ram_wr !== 1'b0) begin n_fail++; $display("FAIL byte_store extra write: ram_wr=%b, required 0", bus.ram_wr); end
    n_chk++;
    if (bus.if_inst !== 32'h00100513) begin
      n_fail++; $display("FAIL byte_store if_inst: got %h, required 00100513", bus.if_inst);
    end
  endtask

  task automatic test_contention();
    int s;
    wait_idle();
    s = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    bus.mem_we = 1'b1; bus.mem_len = 2'b11; bus.mem_addr = 32'h300; bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_req = 1'b1;
`ifdef MEMCTRL_ROUND_ROBIN_EN
    push_exp(1'b0, 1'b1, 32'h00100513, s + 6);
    push_exp(1'b1, 1'b0, 32'h0, s + 12);
`else
    push_exp(1'b1, 1'b0, 32'h0, s + 5);
    push_exp(1'b0, 1'b1, 32'h00100513, s + 12);
`endif
    run_sb("contention", 40);
    bus.mem_we = 1'b0;
    n_chk++;
    if (ram_rd(32'h300) !== 8'hEF || ram_rd(32'h303) !== 8'hDE) begin
      n_fail++; $display("FAIL contention store: ram[300]=%h ram[303]=%h, required ef/de", ram_rd(32'h300), ram_rd(32'h303));
    end
  endtask

  task automatic test_reset_mid_write();
    int s;
    preload(32'h40, 32'h55555500, 4);
    wait_idle();
    bus.mem_we = 1'b1; bus.mem_len = 2'b11; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hA1B2C3D4;
    bus.mem_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'hD4) begin
      n_fail++; $display("FAIL rst_mid first byte: wr=%b d=%h, required 1/d4", bus.ram_wr, bus.ram_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    n_chk++;
    if (bus.ram_wr !== 1'b0 || bus.busy !== 1'b0 || bus.ram_a !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid async: wr=%b busy=%b a=%h, required 0/0/0", bus.ram_wr, bus.busy, bus.ram_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.mem_done !== 1'b0 || bus.if_done !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid done: mem_done=%b if_done=%b, required 0/0", bus.mem_done, bus.if_done);
      end
    end
    rst = 1'b1;
    bus.mem_we = 1'b0;
    wait_idle();
    s = cyc;
    bus.mem_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'h555555D4, s + 6);
    run_sb("rst_mid_reload", 20);
  endtask

  task automatic test_back_to_back();
    int s;
    preload(32'h104, 32'h00000293, 4);
    wait_idle();
    s = cyc;
    chain_addr = 32'h104;
    chain_cnt  = 1;
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    push_exp(1'b0, 1'b1, 32'h00100513, s + 6);
    push_exp(1'b0, 1'b1, 32'h00000293, s + 13);
    run_sb("back_to_back", 40);
  endtask

  initial begin
    rst = 1'b0;
    n_chk = 0; n_fail = 0; cyc = 0;
    pre_we = 1'b0; pre_a = 32'h0; pre_d = 8'h0;
    chain_addr = 32'h0; chain_cnt = 0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    bus.ram_din = 8'h00;
    test_reset();
    test_word_fetch();
    test_wrap();
    test_half_load();
    test_byte_store();
    test_contention();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-wide unified RAM port between instruction fetch (IF) and load/store (MEM).
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or scatters the little-endian bytes.
- Returns one `done` pulse to the granted requester.
- Sits between the IF/MEM stages and the RAM, replacing direct combinational ROM reads with a sequenced, stall-based protocol.

## Interface
Parameters:
- `ADDR_W`, default 32: address width of requester and RAM ports.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  IF fetch request; held until `if_done`.
- `if_addr`  in  ADDR_W  fetch byte address; stable while `if_req`.
- `if_done`  out  1  one-cycle pulse: `if_inst` valid.
- `if_inst`  out  32  fetched word, little-endian.
- `mem_req`  in  1  load/store request; held until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_len`  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes; 10 is treated as 4 bytes.
- `mem_addr`  in  ADDR_W  byte address; unaligned addresses are legal.
- `mem_wdata`  in  32  store data; low `mem_len` bytes are used.
- `mem_done`  out  1  one-cycle pulse: load data valid / store complete.
- `mem_rdata`  out  32  load data, zero-extended above the accessed bytes.
- `ram_a`  out  ADDR_W  RAM byte address.
- `ram_wr`  out  1  1 = write `ram_dout` at `ram_a` this cycle.
- `ram_dout`  out  8  RAM write byte.
- `ram_din`  in  8  RAM read byte, valid one cycle after `ram_a` is presented.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
States: IDLE, BUSY, DONE. A 3-bit byte counter `c`. Latched fields: `base`, `n` (1/2/4), `we`, `wdata`, `owner` (IF or MEM).

IDLE:
- If neither request is high, stay in IDLE.
- Otherwise arbitrate, latch the winner's fields (IF is always a 4-byte read), set `c` = 0, go to BUSY.
- Arbitration: MEM wins over IF when both request (see Configuration).

BUSY, read:
- `ram_a` = `base` + min(`c`, `n`−1); `ram_wr` = 0.
- On each edge with `c` ≥ 1, store `ram_din` into byte `c`−1 of the data register.
- When `c` == `n`, go to DONE. Otherwise increment `c`.
- Data-register bytes at index ≥ `n` are cleared at grant.

BUSY, write:
- `ram_a` = `base` + `c`; `ram_wr` = 1; `ram_dout` = byte `c` of `wdata`.
- When `c` == `n`−1, go to DONE. Otherwise increment `c`.

DONE:
- Pulse `owner`'s done for exactly one cycle.
- On a read, the data register drives `if_inst` or `mem_rdata`.
- Next state is IDLE.

Requester rules and boundaries:
- A requester must deassert `req` in the cycle after its `done`. `req` held longer starts a new transaction.
- Address arithmetic is modulo 2^ADDR_W; `base` = all-ones with `n` = 4 wraps to 0, 1, 2.
- Requests arriving during BUSY/DONE are not lost; they are arbitrated in the next IDLE cycle.
- Changes to `if_addr`/`mem_*` after grant have no effect on the current transaction.
- `if_inst`/`mem_rdata` are registered and hold their last value. The non-owner's data output is not modified.

## Timing
- Reset (asynchronous, immediate): state IDLE, `c` = 0.
- Reset values: `ram_a` = 0, `ram_wr` = 0, `ram_dout` = 0, `if_done` = 0, `mem_done` = 0, `if_inst` = 0, `mem_rdata` = 0, `busy` = 0.
- Reset mid-transaction: the transaction is abandoned, no `done` is issued, and `ram_wr` drops without waiting for a clock.
- IDLE outputs: `ram_a` = 0, `ram_wr` = 0, `ram_dout` = 0.
- Latency from the first IDLE cycle in which `req` is sampled high (cycle 0):
  - read of `n` bytes: `done` in cycle `n`+2; word fetch `done` in cycle 6.
  - write of `n` bytes: `done` in cycle `n`+1; word store `done` in cycle 5.
- Back-to-back: at least one IDLE cycle separates transactions; a word-fetch stream has a period of 7 cycles.
- All outputs are registered or decoded from registered state; there are no combinational paths from `*_req` to `ram_*`.

## Configuration
- `MEMCTRL_ROUND_ROBIN_EN` defined: a 1-bit `last_owner` register, reset to IF, records the winner of each grant. On a simultaneous request, the requester that did not win the previous grant wins.
- Undefined: fixed priority, MEM always beats IF, and `last_owner` is absent. IF can starve only while MEM issues requests continuously.

## Test plan
- **Word fetch:** RAM holds 0x13,0x05,0x10,0x00 at 0x100; `if_req` with `if_addr` = 0x100 → `ram_a` = 0x100..0x103, then 0x103 held one cycle; `if_done` in cycle 6 with `if_inst` = 0x00100513.
- **Unaligned half load:** bytes 0xAB,0xCD at 0x201; `mem_len` = 01, `mem_addr` = 0x201 → `mem_done` in cycle 4, `mem_rdata` = 0x0000CDAB.
- **Byte store:** `mem_we` = 1, `mem_len` = 00, `mem_addr` = 0x30, `mem_wdata` = 0x11223344 → single cycle with `ram_wr` = 1, `ram_a` = 0x30, `ram_dout` = 0x44; `mem_done` in cycle 2; `if_inst` unchanged.
- **Contention:** `if_req` and `mem_req` rise in the same cycle.
  - Macro off: MEM is served first, then IF.
  - Macro on, after a prior MEM grant: IF is served first.
  - Neither request is dropped.
- **Wrap-around:** `mem_addr` = 0xFFFFFFFF, `mem_len` = 11 load → `ram_a` = 0xFFFFFFFF, 0, 1, 2.
- **Reset mid-write:** `rst` low during the second byte of a word store → `ram_wr` = 0 immediately, no `mem_done`, `busy` = 0; after release, a fresh request completes normally.
